// File: rtl/cache_wb_assoc.sv
// cache_wb_assoc: 2-way set-associative, write-back / write-allocate cache.
// Sits between the CPU bus (C1) and the memory bus (C2). Lines are filled and evicted as
// BEATS consecutive BUS_SIZE-wide beats; LRU replacement per set.
// Ports:
//   clk, reset (async, active-low)
//   cpu_cmd_in/cpu_addr/cpu_data_in  C1 request (NOP,RD8,RD16,RD32,INV_LINE,WR8,WR16,WR32)
//   cpu_busy                         1 = new command not accepted
//   cpu_cmd_out/cpu_data_out         7 plus data on every response beat
//   mem_addr/mem_cmd_out/mem_data_out C2 request: line address, READ(2)/WRITE(3), write-back beat
//   mem_cmd_in/mem_data_in           C2 response (1) with fill beat data
module cache_wb_assoc #(
   parameter int unsigned BUS_SIZE          = 16,
   parameter int unsigned MEM_ADDR_SIZE     = 19,
   parameter int unsigned CACHE_OFFSET_SIZE = 4,
   parameter int unsigned CACHE_LINE_SIZE   = 16,
   parameter int unsigned CACHE_SET_SIZE    = 5
) (
   input  logic                                         clk,
   input  logic                                         reset,
   input  logic [2:0]                                   cpu_cmd_in,
   input  logic [MEM_ADDR_SIZE-1:0]                     cpu_addr,
   input  logic [BUS_SIZE-1:0]                          cpu_data_in,
   output logic                                         cpu_busy,
   output logic [2:0]                                   cpu_cmd_out,
   output logic [BUS_SIZE-1:0]                          cpu_data_out,
   output logic [MEM_ADDR_SIZE-CACHE_OFFSET_SIZE-1:0]   mem_addr,
   output logic [1:0]                                   mem_cmd_out,
   output logic [BUS_SIZE-1:0]                          mem_data_out,
   input  logic [1:0]                                   mem_cmd_in,
   input  logic [BUS_SIZE-1:0]                          mem_data_in
);

   localparam int unsigned TAG       = MEM_ADDR_SIZE - CACHE_SET_SIZE - CACHE_OFFSET_SIZE;
   localparam int unsigned SETS      = 2 ** CACHE_SET_SIZE;
   localparam int unsigned LINE_BITS = CACHE_LINE_SIZE * 8;
   localparam int unsigned BEATS     = LINE_BITS / BUS_SIZE;
   localparam int unsigned WBEATS    = 32 / BUS_SIZE;
   localparam int unsigned CW        = 8;

   localparam logic [CW-1:0] BEATS_LAST  = CW'(BEATS - 1);
   localparam logic [CW-1:0] WBEATS_N    = CW'(WBEATS);
   localparam logic [CW-1:0] WBEATS_LAST = CW'(WBEATS - 1);

   localparam logic [2:0] C1_NOP  = 3'd0;
   localparam logic [2:0] C1_RD8  = 3'd1;
   localparam logic [2:0] C1_RD16 = 3'd2;
   localparam logic [2:0] C1_RD32 = 3'd3;
   localparam logic [2:0] C1_INV  = 3'd4;
   localparam logic [2:0] C1_WR16 = 3'd6;
   localparam logic [2:0] C1_WR32 = 3'd7;
   localparam logic [2:0] C1_RESP = 3'd7;

   localparam logic [1:0] C2_NOP   = 2'd0;
   localparam logic [1:0] C2_RESP  = 2'd1;
   localparam logic [1:0] C2_READ  = 2'd2;
   localparam logic [1:0] C2_WRITE = 2'd3;

   typedef enum logic [2:0] {
      StIdle, StCollect, StLookup, StResp, StEvict, StEvictWait, StFillReq, StFill
   } state_e;

   state_e                          state_q;
   logic [2:0]                      cmd_q;
   logic [MEM_ADDR_SIZE-1:0]        addr_q;
   logic [31:0]                     wdata_q;
   logic                            way_q;
   logic [CW-1:0]                   beat_q;
   logic [1:0][SETS-1:0]            valid_q;
   logic [1:0][SETS-1:0]            dirty_q;
   logic [SETS-1:0]                 lru_q;
   logic [1:0][SETS-1:0][TAG-1:0]   tag_q;
   logic [LINE_BITS-1:0]            data_q [2][SETS];

   logic [CACHE_SET_SIZE-1:0]       set_idx;
   logic [TAG-1:0]                  tag_cur;
   logic [CACHE_OFFSET_SIZE-1:0]    off;
   logic                            hit0, hit1, hit, hit_way, victim, acc_way;
   logic                            is_inv, is_wr;
   logic [LINE_BITS-1:0]            line_rd, merged;
   logic [31:0]                     rd32;
   logic [BUS_SIZE-1:0]             resp_data;
   logic [CW-1:0]                   resp_beats;
   int unsigned                     nbytes;

   assign set_idx = addr_q[CACHE_OFFSET_SIZE +: CACHE_SET_SIZE];
   assign tag_cur = addr_q[MEM_ADDR_SIZE-1 -: TAG];
   assign off     = addr_q[CACHE_OFFSET_SIZE-1:0];
   assign hit0    = valid_q[0][set_idx] && (tag_q[0][set_idx] == tag_cur);
   assign hit1    = valid_q[1][set_idx] && (tag_q[1][set_idx] == tag_cur);
   assign hit     = hit0 | hit1;
   assign hit_way = hit1;
   // Invalid ways are preferred (way0 first); only a full set falls back to LRU.
   assign victim  = !valid_q[0][set_idx] ? 1'b0 : !valid_q[1][set_idx] ? 1'b1 : lru_q[set_idx];
   assign acc_way = (state_q == StLookup) ? hit_way : way_q;
   assign line_rd = data_q[acc_way][set_idx];
   assign is_inv  = (cmd_q == C1_INV);
   assign is_wr   = cmd_q[2] && !is_inv;

   always_comb begin
      merged = line_rd;
      case (cmd_q)
         C1_WR16: nbytes = 2;
         C1_WR32: nbytes = 4;
         default: nbytes = 1;
      endcase
      for (int b = 0; b < 4; b++) begin
         if (b < int'(nbytes)) merged[(int'(off) + b) * 8 +: 8] = wdata_q[b * 8 +: 8];
      end
      rd32 = 32'(line_rd >> (int'(off) * 8));
      case (cmd_q)
         C1_RD8:  rd32 = rd32 & 32'h0000_00ff;
         C1_RD16: rd32 = rd32 & 32'h0000_ffff;
         C1_RD32: rd32 = rd32;
         default: rd32 = '0;
      endcase
      resp_data  = BUS_SIZE'(rd32 >> (int'(beat_q) * BUS_SIZE));
      resp_beats = (cmd_q == C1_RD32) ? WBEATS_N : CW'(1);
   end

   // Line storage needs no reset: valid bits gate every use of it.
   always_ff @(posedge clk) begin
      if (state_q == StFill && mem_cmd_in == C2_RESP) begin
         data_q[way_q][set_idx][int'(beat_q) * BUS_SIZE +: BUS_SIZE] <= mem_data_in;
      end else if (state_q == StLookup && is_wr && hit) begin
         data_q[hit_way][set_idx] <= merged;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= StIdle;
         cmd_q        <= C1_NOP;
         addr_q       <= '0;
         wdata_q      <= '0;
         way_q        <= 1'b0;
         beat_q       <= '0;
         valid_q      <= '0;
         dirty_q      <= '0;
         lru_q        <= '0;
         tag_q        <= '0;
         cpu_busy     <= 1'b0;
         cpu_cmd_out  <= C1_NOP;
         cpu_data_out <= '0;
         mem_addr     <= '0;
         mem_cmd_out  <= C2_NOP;
         mem_data_out <= '0;
      end else begin
         cpu_cmd_out  <= C1_NOP;
         cpu_data_out <= '0;
         mem_cmd_out  <= C2_NOP;
         mem_data_out <= '0;
         unique case (state_q)
            StIdle: begin
               if (cpu_cmd_in != C1_NOP) begin
                  cmd_q    <= cpu_cmd_in;
                  addr_q   <= cpu_addr;
                  if (cpu_cmd_in == C1_RD16 || cpu_cmd_in == C1_WR16) addr_q[0] <= 1'b0;
                  if (cpu_cmd_in == C1_RD32 || cpu_cmd_in == C1_WR32) addr_q[1:0] <= 2'b00;
                  wdata_q  <= 32'(cpu_data_in);
                  beat_q   <= CW'(1);
                  cpu_busy <= 1'b1;
                  state_q  <= (cpu_cmd_in == C1_WR32 && WBEATS > 1) ? StCollect : StLookup;
               end
            end
            StCollect: begin
               // Remaining WR32 beats arrive on consecutive cycles, low half first.
               wdata_q[int'(beat_q) * BUS_SIZE +: BUS_SIZE] <= cpu_data_in;
               beat_q <= beat_q + 1'b1;
               if (beat_q == WBEATS_LAST) state_q <= StLookup;
            end
            StLookup: begin
               beat_q <= '0;
               if (is_inv) begin
                  way_q <= hit_way;
                  if (hit && dirty_q[hit_way][set_idx]) begin
                     state_q <= StEvict;
                  end else begin
                     if (hit) valid_q[hit_way][set_idx] <= 1'b0;
                     state_q <= StResp;
                  end
               end else if (hit) begin
                  way_q          <= hit_way;
                  lru_q[set_idx] <= !hit_way;
                  if (is_wr) dirty_q[hit_way][set_idx] <= 1'b1;
                  state_q <= StResp;
               end else begin
                  way_q   <= victim;
                  state_q <= (valid_q[victim][set_idx] && dirty_q[victim][set_idx]) ?
                             StEvict : StFillReq;
               end
            end
            StResp: begin
               if (beat_q < resp_beats) begin
                  cpu_cmd_out  <= C1_RESP;
                  cpu_data_out <= is_wr ? '0 : resp_data;
                  beat_q       <= beat_q + 1'b1;
               end else begin
                  cpu_busy <= 1'b0;
                  state_q  <= StIdle;
               end
            end
            StEvict: begin
               mem_cmd_out  <= C2_WRITE;
               mem_addr     <= {tag_q[way_q][set_idx], set_idx};
               mem_data_out <= line_rd[int'(beat_q) * BUS_SIZE +: BUS_SIZE];
               beat_q       <= beat_q + 1'b1;
               if (beat_q == BEATS_LAST) state_q <= StEvictWait;
            end
            StEvictWait: begin
               if (mem_cmd_in == C2_RESP) begin
                  dirty_q[way_q][set_idx] <= 1'b0;
                  // INV_LINE re-looks up the now-clean line to drop it.
                  state_q <= is_inv ? StLookup : StFillReq;
               end
            end
            StFillReq: begin
               mem_cmd_out <= C2_READ;
               mem_addr    <= {tag_cur, set_idx};
               beat_q      <= '0;
               state_q     <= StFill;
            end
            StFill: begin
               if (mem_cmd_in == C2_RESP) begin
                  beat_q <= beat_q + 1'b1;
                  if (beat_q == BEATS_LAST) begin
                     valid_q[way_q][set_idx] <= 1'b1;
                     dirty_q[way_q][set_idx] <= 1'b0;
                     tag_q[way_q][set_idx]   <= tag_cur;
                     lru_q[set_idx]          <= !way_q;
                     state_q                 <= StLookup;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_cache_wb_assoc.sv
module tb_cache_wb_assoc;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  cpu_cmd_in;
   logic [18:0] cpu_addr;
   logic [15:0] cpu_data_in;
   logic        cpu_busy;
   logic [2:0]  cpu_cmd_out;
   logic [15:0] cpu_data_out;
   logic [14:0] mem_addr;
   logic [1:0]  mem_cmd_out;
   logic [15:0] mem_data_out;
   logic [1:0]  mem_cmd_in;
   logic [15:0] mem_data_in;

   cache_wb_assoc dut (
      .clk          (clk),
      .reset        (reset),
      .cpu_cmd_in   (cpu_cmd_in),
      .cpu_addr     (cpu_addr),
      .cpu_data_in  (cpu_data_in),
      .cpu_busy     (cpu_busy),
      .cpu_cmd_out  (cpu_cmd_out),
      .cpu_data_out (cpu_data_out),
      .mem_addr     (mem_addr),
      .mem_cmd_out  (mem_cmd_out),
      .mem_data_out (mem_data_out),
      .mem_cmd_in   (mem_cmd_in),
      .mem_data_in  (mem_data_in)
   );

   initial forever #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic [15:0]  exp_q     [$];   // expected CPU response beats
   logic [16:0]  exp_mem_q [$];   // expected {cmd, line address} memory requests
   logic [15:0]  exp_wr_q  [$];   // expected write-back beats
   logic [127:0] mem_line  [int];

   longint acc_t, first_t;
   bit     got_first;
   int     fill_sent = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] line_beat(input int la, input int i);
      logic [127:0] l;
      if (mem_line.exists(la)) begin
         l = mem_line[la];
         return l[i * 16 +: 16];
      end
      return 16'(la) + 16'(i) * 16'h1000;
   endfunction

   task automatic mem_expect(input logic [1:0] cmd, input logic [14:0] addr);
      logic [16:0] e;
      if (exp_mem_q.size() == 0) begin
         check("mem_extra", 32'(exp_mem_q.size()), 32'd1);
      end else begin
         e = exp_mem_q.pop_front();
         check("mem_cmd", 32'(cmd), 32'(e[16:15]));
         check("mem_addr", 32'(addr), 32'(e[14:0]));
      end
   endtask

   // CPU response monitor
   initial forever begin
      @(posedge clk);
      #1;
      if (cpu_cmd_out == 3'd7) begin
         if (!got_first) begin
            first_t   = longint'($time);
            got_first = 1'b1;
         end
         if (exp_q.size() == 0) check("resp_extra", 32'(exp_q.size()), 32'd1);
         else check("resp_data", 32'(cpu_data_out), 32'(exp_q.pop_front()));
      end
   end

   // Memory model: absorbs write-backs, answers line reads
   initial begin
      int wcnt = 0;
      int la;
      logic [127:0] wline = '0;
      mem_cmd_in  = 2'd0;
      mem_data_in = 16'd0;
      forever begin
         @(posedge clk);
         #1;
         if (reset && mem_cmd_out == 2'd3) begin
            if (wcnt == 0) mem_expect(2'd3, mem_addr);
            if (exp_wr_q.size() == 0) check("wr_extra", 32'(exp_wr_q.size()), 32'd1);
            else check("wr_beat", 32'(mem_data_out), 32'(exp_wr_q.pop_front()));
            wline[wcnt * 16 +: 16] = mem_data_out;
            wcnt++;
            if (wcnt == 8) begin
               mem_line[int'(mem_addr)] = wline;
               wcnt = 0;
               @(posedge clk);
               #1 mem_cmd_in = 2'd1;
               @(posedge clk);
               #1 mem_cmd_in = 2'd0;
            end
         end else if (reset && mem_cmd_out == 2'd2) begin
            mem_expect(2'd2, mem_addr);
            la        = int'(mem_addr);
            fill_sent = 0;
            for (int i = 0; i < 8; i++) begin
               @(posedge clk);
               #1;
               if (!reset) break;
               mem_cmd_in  = 2'd1;
               mem_data_in = line_beat(la, i);
               fill_sent++;
            end
            if (reset) begin
               @(posedge clk);
               #1;
            end
            mem_cmd_in  = 2'd0;
            mem_data_in = 16'd0;
         end
      end
   end

   task automatic cpu_issue(input logic [2:0] cmd, input logic [18:0] addr, input logic [31:0] wd);
      int n = 0;
      @(negedge clk);
      while (cpu_busy && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("idle_before_issue", 32'(cpu_busy), 32'd0);
      cpu_cmd_in  = cmd;
      cpu_addr    = addr;
      cpu_data_in = wd[15:0];
      got_first   = 1'b0;
      @(posedge clk);
      acc_t = longint'($time);
      @(negedge clk);
      cpu_cmd_in  = 3'd0;
      cpu_data_in = wd[31:16];
      @(negedge clk);
      cpu_data_in = 16'd0;
   endtask

   task automatic cpu_wait_done(input string tag);
      int n = 0;
      while (cpu_busy && n < 300) begin
         @(negedge clk);
         n++;
      end
      check(tag, 32'(cpu_busy), 32'd0);
      check("resp_left", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic run_op(input string tag, input logic [2:0] cmd, input logic [18:0] addr,
                         input logic [31:0] wd);
      cpu_issue(cmd, addr, wd);
      cpu_wait_done(tag);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] l;
      int n;
      reset       = 1'b0;
      cpu_cmd_in  = 3'd0;
      cpu_addr    = '0;
      cpu_data_in = 16'd0;
      for (int i = 0; i < 8; i++) l[i * 16 +: 16] = 16'h1100 + 16'(i);
      mem_line[32'h12] = l;

      repeat (2) @(negedge clk);
      check("rst_busy", 32'(cpu_busy), 32'd0);
      check("rst_cmd_out", 32'(cpu_cmd_out), 32'd0);
      check("rst_data_out", 32'(cpu_data_out), 32'd0);
      check("rst_mem_cmd", 32'(mem_cmd_out), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_mem_data", 32'(mem_data_out), 32'd0);
      reset = 1'b1;

      // 1: cold read miss, clean fill
      exp_mem_q.push_back({2'd2, 15'h0012});
      exp_q.push_back(16'h0011);
      run_op("t1_rd8", 3'd1, 19'h00123, 32'd0);

      // 2: RD32 hit, two beats, 2 cycles after accept
      exp_q.push_back(16'h1100);
      exp_q.push_back(16'h1101);
      run_op("t2_rd32", 3'd3, 19'h00120, 32'd0);
      check("t2_latency", 32'((first_t - acc_t) / 10), 32'd2);

      // 3: WR16 hit then misaligned RD16 (aligned down)
      exp_q.push_back(16'h0000);
      run_op("t3_wr16", 3'd6, 19'h00124, 32'h0000_beef);
      exp_q.push_back(16'hbeef);
      run_op("t3_rd16", 3'd2, 19'h00125, 32'd0);
      check("t3_latency", 32'((first_t - acc_t) / 10), 32'd2);

      // 4: fill way1, WR32 two-beat write, then third line evicts dirty 0x00120 line
      exp_mem_q.push_back({2'd2, 15'h0812});
      exp_q.push_back(16'h0012);
      run_op("t4_rd8", 3'd1, 19'h08120, 32'd0);
      exp_q.push_back(16'h0000);
      run_op("t4_wr32", 3'd7, 19'h08126, 32'hd00d_cafe);
      exp_q.push_back(16'hcafe);
      exp_q.push_back(16'hd00d);
      run_op("t4_rd32", 3'd3, 19'h08124, 32'd0);
      exp_mem_q.push_back({2'd3, 15'h0012});
      exp_mem_q.push_back({2'd2, 15'h1012});
      for (int i = 0; i < 8; i++) exp_wr_q.push_back(i == 2 ? 16'hbeef : 16'h1100 + 16'(i));
      exp_q.push_back(16'h2012);
      run_op("t4_rd16", 3'd2, 19'h10122, 32'd0);

      // 5: dirty INV_LINE writes back then drops the line
      exp_q.push_back(16'h0000);
      run_op("t5_wr8", 3'd5, 19'h10121, 32'h0000_0077);
      exp_mem_q.push_back({2'd3, 15'h1012});
      for (int i = 0; i < 8; i++) exp_wr_q.push_back(i == 0 ? 16'h7712 : 16'h1012 + 16'(i) * 16'h1000);
      exp_q.push_back(16'h0000);
      run_op("t5_inv", 3'd4, 19'h10120, 32'd0);
      exp_mem_q.push_back({2'd2, 15'h1012});
      exp_q.push_back(16'h0077);
      run_op("t5_rd8", 3'd1, 19'h10121, 32'd0);
      exp_q.push_back(16'h0000);
      run_op("t5_inv_clean", 3'd4, 19'h10120, 32'd0);
      exp_mem_q.push_back({2'd2, 15'h1012});
      exp_q.push_back(16'h0012);
      run_op("t5_rd8_again", 3'd1, 19'h10120, 32'd0);
      exp_q.push_back(16'h0000);
      run_op("t5_inv_miss", 3'd4, 19'h00000, 32'd0);

      // 6: reset during fill
      exp_mem_q.push_back({2'd2, 15'h0023});
      cpu_issue(3'd1, 19'h00230, 32'd0);
      n = 0;
      while (fill_sent != 4 && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("t6_fill_beats", 32'(fill_sent), 32'd4);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("t6_busy", 32'(cpu_busy), 32'd0);
      check("t6_cmd_out", 32'(cpu_cmd_out), 32'd0);
      check("t6_data_out", 32'(cpu_data_out), 32'd0);
      check("t6_mem_cmd", 32'(mem_cmd_out), 32'd0);
      check("t6_mem_addr", 32'(mem_addr), 32'd0);
      check("t6_mem_data", 32'(mem_data_out), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      exp_mem_q.push_back({2'd2, 15'h0023});
      exp_q.push_back(16'h0023);
      run_op("t6_rd8", 3'd1, 19'h00230, 32'd0);

      repeat (4) @(negedge clk);
      check("sb_resp_left", 32'(exp_q.size()), 32'd0);
      check("sb_mem_left", 32'(exp_mem_q.size()), 32'd0);
      check("sb_wr_left", 32'(exp_wr_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
